// File: rtl/sequence_generator.sv
// Serial "w" stream source: shifts a captured pattern out MSB-first, optionally
// repeating it with forced-zero gap bits between frames.
//   state | meaning
//   IDLE  | waiting for start, w held low
//   SEND  | one pattern bit per clk on w
//   GAP   | forced-zero bits between frames
//   DONE  | single-cycle done pulse
module sequence_generator #(
    parameter int WIDTH    = 8,
    parameter int GAP_BITS = 1,
    parameter int RPT_W    = 4,
    localparam int LEN_W   = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    input  logic [RPT_W-1:0] rpt,
    output logic             w,
    output logic             w_valid,
    output logic             busy,
    output logic             done,
    output logic             err
);
    localparam int GAP_W = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
    localparam logic [LEN_W-1:0] WIDTH_L  = LEN_W'(WIDTH);
    localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'(GAP_BITS - 1);

    typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pat_q, pat_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] idx_q, idx_d;
    logic [RPT_W-1:0] rpt_q, rpt_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             w_q, w_d;
    logic             w_valid_q, w_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] aligned;

    // Pattern is left-aligned so the first bit to send is always the MSB.
    assign aligned = pattern << (WIDTH_L - len);

    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        sh_d      = sh_q;
        len_d     = len_q;
        idx_d     = idx_q;
        rpt_d     = rpt_q;
        gap_d     = gap_q;
        w_d       = 1'b0;
        w_valid_d = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (len == '0 || len > WIDTH_L) begin
                        err_d = 1'b1;
                    end else begin
                        pat_d     = aligned;
                        sh_d      = aligned;
                        len_d     = len;
                        idx_d     = len - LEN_W'(1);
                        rpt_d     = rpt;
                        w_d       = aligned[WIDTH-1];
                        w_valid_d = 1'b1;
                        busy_d    = 1'b1;
                        state_d   = SEND;
                    end
                end
            end
            SEND: begin
                busy_d = 1'b1;
                if (idx_q != '0) begin
                    idx_d     = idx_q - LEN_W'(1);
                    sh_d      = sh_q << 1;
                    w_d       = sh_q[WIDTH-2];
                    w_valid_d = 1'b1;
                end else if (rpt_q != '0) begin
                    rpt_d = rpt_q - RPT_W'(1);
                    if (GAP_BITS > 0) begin
                        gap_d   = GAP_INIT;
                        state_d = GAP;
                    end else begin
                        sh_d      = pat_q;
                        idx_d     = len_q - LEN_W'(1);
                        w_d       = pat_q[WIDTH-1];
                        w_valid_d = 1'b1;
                    end
                end else begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            GAP: begin
                busy_d = 1'b1;
                if (gap_q == '0) begin
                    sh_d      = pat_q;
                    idx_d     = len_q - LEN_W'(1);
                    w_d       = pat_q[WIDTH-1];
                    w_valid_d = 1'b1;
                    state_d   = SEND;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pat_q     <= '0;
            sh_q      <= '0;
            len_q     <= '0;
            idx_q     <= '0;
            rpt_q     <= '0;
            gap_q     <= '0;
            w_q       <= 1'b0;
            w_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pat_q     <= pat_d;
            sh_q      <= sh_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            rpt_q     <= rpt_d;
            gap_q     <= gap_d;
            w_q       <= w_d;
            w_valid_q <= w_valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign w       = w_q;
    assign w_valid = w_valid_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;
endmodule

// File: tb/tb_sequence_generator.sv
// Bench for sequence_generator: one instance with a single gap bit, one with
// back-to-back frames; per-cycle expected outputs come from a scoreboard queue.
module tb_sequence_generator;
    localparam int WIDTH = 8;
    localparam int RPT_W = 4;
    localparam int LEN_W = $clog2(WIDTH + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             start0 = 1'b0;
    logic [WIDTH-1:0] pattern = '0;
    logic [LEN_W-1:0] len = '0;
    logic [RPT_W-1:0] rpt = '0;
    logic             w, w_valid, busy, done, err;
    logic             w0, w_valid0, busy0, done0, err0;

    // expected {w, w_valid, busy, done, err}; empty queue means idle (all zero)
    logic [4:0] q[$];
    logic [4:0] q0[$];
    int         n_assert = 0;
    int         n_fail   = 0;
    int         busy_cnt = 0;
    int         busy_cnt0 = 0;
    string      tag = "reset";

    sequence_generator #(.WIDTH(WIDTH), .GAP_BITS(1), .RPT_W(RPT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .pattern(pattern), .len(len), .rpt(rpt),
        .w(w), .w_valid(w_valid), .busy(busy), .done(done), .err(err)
    );

    sequence_generator #(.WIDTH(WIDTH), .GAP_BITS(0), .RPT_W(RPT_W)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .pattern(pattern), .len(len), .rpt(rpt),
        .w(w0), .w_valid(w_valid0), .busy(busy0), .done(done0), .err(err0)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push_frames(input logic [WIDTH-1:0] p, input int l, input int r,
                               input int g, input bit to0);
        logic [4:0] e;
        for (int f = 0; f <= r; f++) begin
            for (int b = l - 1; b >= 0; b--) begin
                e = {p[b], 1'b1, 1'b1, 1'b0, 1'b0};
                if (to0) q0.push_back(e); else q.push_back(e);
            end
            if (f < r) begin
                for (int k = 0; k < g; k++) begin
                    e = 5'b00100;
                    if (to0) q0.push_back(e); else q.push_back(e);
                end
            end
        end
        if (to0) q0.push_back(5'b00010); else q.push_back(5'b00010);
    endtask

    task automatic tick();
        logic [4:0] e, e0, o, o0;
        @(posedge clk);
        @(negedge clk);
        e  = 5'b0;
        e0 = 5'b0;
        if (q.size() > 0) e = q.pop_front();
        if (q0.size() > 0) e0 = q0.pop_front();
        o  = {w, w_valid, busy, done, err};
        o0 = {w0, w_valid0, busy0, done0, err0};
        if (busy) busy_cnt++;
        if (busy0) busy_cnt0++;
        n_assert++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s gap1 {w,vld,busy,done,err} observed=%b expected=%b", tag, o, e);
        end
        n_assert++;
        assert (o0 === e0) else begin
            n_fail++;
            $error("FAIL %s gap0 {w,vld,busy,done,err} observed=%b expected=%b", tag, o0, e0);
        end
    endtask

    task automatic drain();
        while (q.size() > 0 || q0.size() > 0) tick();
    endtask

    task automatic check_busy(input int obs, input int exp_v);
        n_assert++;
        assert (obs == exp_v) else begin
            n_fail++;
            $error("FAIL %s busy_cycles observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    initial begin
        @(negedge clk);
        tick();
        tick();
        rst = 1'b0;
        tick();

        tag = "single_frame";
        pattern = 8'b0110_1110; len = 8; rpt = 0; start = 1'b1;
        push_frames(8'b0110_1110, 8, 0, 1, 1'b0);
        busy_cnt = 0;
        tick();
        start = 1'b0;
        drain();
        check_busy(busy_cnt, 8);
        tick();

        tag = "repeat_gap";
        pattern = 8'h03; len = 2; rpt = 2; start = 1'b1;
        push_frames(8'h03, 2, 2, 1, 1'b0);
        busy_cnt = 0;
        tick();
        start = 1'b0;
        tick();
        tag = "start_in_send";
        pattern = 8'hFF; len = 8; rpt = 5; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        drain();
        tag = "start_in_done";
        check_busy(busy_cnt, 8);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();

        tag = "back_to_back";
        pattern = 8'h01; len = 1; rpt = 3; start0 = 1'b1;
        push_frames(8'h01, 1, 3, 0, 1'b1);
        busy_cnt0 = 0;
        tick();
        start0 = 1'b0;
        drain();
        check_busy(busy_cnt0, 4);
        tick();

        tag = "reject_len0";
        pattern = 8'hAA; len = 0; rpt = 0; start = 1'b1;
        q.push_back(5'b00001);
        tick();
        start = 1'b0;
        tick();
        tick();
        tag = "reject_len9";
        len = 9; start = 1'b1;
        q.push_back(5'b00001);
        tick();
        start = 1'b0;
        tick();
        tick();

        tag = "reset_mid_frame";
        pattern = 8'b1011_0010; len = 8; rpt = 0; start = 1'b1;
        push_frames(8'b1011_0010, 8, 0, 1, 1'b0);
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        q.delete();
        tick();
        rst = 1'b0;
        tick();
        tick();
        tag = "after_reset";
        pattern = 8'b0100_0111; len = 7; rpt = 1; start = 1'b1;
        push_frames(8'b0100_0111, 7, 1, 1, 1'b0);
        busy_cnt = 0;
        tick();
        start = 1'b0;
        drain();
        check_busy(busy_cnt, 15);
        tick();

        tag = "max_repeat";
        pattern = 8'h05; len = 3; rpt = 15; start = 1'b1;
        push_frames(8'h05, 3, 15, 1, 1'b0);
        busy_cnt = 0;
        tick();
        start = 1'b0;
        drain();
        check_busy(busy_cnt, 63);
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/sequence_generator.md
Name: sequence_generator

Overview:
- Serial bit-stream transmitter: the source end of the single-bit "w" interface consumed by the team's serial sequence detectors.
- Accepts a parallel pattern word with a one-cycle start strobe and shifts it out MSB-first, one bit per clk.
- Can repeat the frame a programmable number of times with forced-zero gap bits between frames, so that runs of 1s do not carry over between frames.
- Used as on-chip stimulus and loopback source for detector blocks.

Parameters:
- WIDTH, 8, maximum pattern length in bits (2..32).
- GAP_BITS, 1, number of forced-0 bit times inserted between repeated frames (0 = back-to-back frames).
- RPT_W, 4, width of the repeat field.

Ports:
- clk  input  1  rising-edge clock; all state changes on posedge clk.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to send; sampled only in IDLE.
- pattern  input  WIDTH  bits to send; bit len-1 is sent first, bit 0 last.
- len  input  $clog2(WIDTH+1)  number of pattern bits per frame; valid range 1..WIDTH.
- rpt  input  RPT_W  extra repetitions; frames sent = rpt+1.
- w  output  1  serial data bit (registered).
- w_valid  output  1  high while w carries a pattern bit; low during gap, idle and done.
- busy  output  1  high in SEND and GAP.
- done  output  1  one-cycle pulse after the final bit of the final frame.
- err  output  1  one-cycle pulse when start is rejected.

Behaviour:
- Reset (rst=1 at posedge) values: state=IDLE; w=0, w_valid=0, busy=0, done=0, err=0; shift register and counters cleared.
- rst wins over every other input in the same cycle.
- rst mid-operation aborts the stream immediately: w=0 from the next cycle, no done pulse.
- All outputs are registered. There are four states: IDLE, SEND, GAP, DONE.
- IDLE:
  - w=0, w_valid=0.
  - start=1 with 1<=len<=WIDTH: capture pattern, len and rpt at that edge; go to SEND.
  - First bit (pattern[len-1]) appears on w with w_valid=1 in the cycle after start is sampled. Latency = 1 clk.
  - start=1 with len=0 or len>WIDTH: stay in IDLE, err=1 for one cycle, nothing is captured.
- SEND:
  - Emits one bit per cycle: pattern[len-1] down to pattern[0], exactly len cycles, w_valid=1 throughout.
  - Captured values are used for every frame. Changes on the pattern, len and rpt inputs while busy are ignored.
- End of frame:
  - Frames remaining and GAP_BITS>0: go to GAP.
  - Frames remaining and GAP_BITS=0: the next frame's first bit follows the previous last bit with no idle cycle.
  - Final frame done: go to DONE.
- GAP: w=0, w_valid=0, busy=1 for exactly GAP_BITS cycles, then return to SEND with the bit index reloaded to len-1.
- DONE:
  - Exactly one cycle: done=1, busy=0, w=0, w_valid=0; then IDLE.
  - start during DONE is ignored; no err.
- start while busy: ignored, no err, no effect on the stream.
- rpt=0 sends a single frame; rpt=2^RPT_W-1 sends 2^RPT_W frames. The repeat counter must not wrap early.
- len=1: each frame is one bit time.
- Bit index counter and frame counter are sized so that len=WIDTH and maximum rpt do not overflow.
- Total busy cycles = (rpt+1)*len + rpt*GAP_BITS.

Test Plan:
- Single frame: reset, then start with pattern=8'b0110_1110, len=8, rpt=0.
  - w=0,1,1,0,1,1,1,0 on cycles 1..8 after start, w_valid=1 on cycles 1..8.
  - done=1 only on cycle 9; busy high on cycles 1..8 exactly.
- Repeat with gap (GAP_BITS=1): pattern=8'h03, len=2, rpt=2.
  - w stream 1,1,0(gap),1,1,0(gap),1,1; w_valid low only in gap cycles.
  - done on cycle 9; busy for 8 cycles.
- Back-to-back (GAP_BITS=0): pattern=8'h01, len=1, rpt=3.
  - w=1 for 4 consecutive cycles with w_valid=1; done on cycle 5.
- Reject: start with len=0, and separately with len=9 (WIDTH=8).
  - err=1 for one cycle, busy stays 0, w stays 0, no done.
  - start asserted during SEND of a valid frame: stream unchanged, no err.
- Reset mid-frame: rst=1 on the 4th bit of an 8-bit frame.
  - Next cycle w=0, w_valid=0, busy=0, no done.
  - A new start afterwards sends the new pattern from its first bit.
- Max repeat (RPT_W=4): pattern=8'h05, len=3, rpt=15, GAP_BITS=1.
  - Exactly 16 frames of 1,0,1 are sent; busy for 63 cycles; single done pulse.
